// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic OWN_IF       = 1'b0;
    localparam logic OWN_D        = 1'b1;
    localparam logic TIMEOUT_FILL = 1'b0;

    // Round-robin pick: data wins unless fetch also waits and data was served last.
    function automatic logic pick_data(input logic if_req, input logic d_req, input logic last_d);
        return d_req & (~if_req | ~last_d);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory handshakes seen by the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_mem;
    logic              err;

    // Arbiter side: serves the pipeline and drives the memory port.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem, err
    );

    // Pipeline plus memory side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Counts BUSY cycles without mem_ready; expired flags the last allowed cycle.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Wait counter, cleared whenever no access is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && !expired) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign expired = (cnt_r == LAST_CNT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to fetch or data, one access at a time,
// with round-robin on contention and a watchdog that forces completion.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [DATA_W-1:0] FILL_WORD = {DATA_W{TIMEOUT_FILL}};

    arb_state_e        state_r, state_s;
    logic              owner_r, last_d_r;
    logic              mem_req_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r, if_rdata_r, d_rdata_r;
    logic              if_done_r, d_done_r, err_r;
    logic              grant_d_s, start_s, ready_s, timeout_s, finish_s;
    logic              wd_clr_s, wd_en_s, expired_s;

    assign grant_d_s = pick_data(bus.if_req, bus.d_req, last_d_r);
    assign finish_s  = ready_s | timeout_s;
    assign wd_clr_s  = (state_r != BUSY);
    assign wd_en_s   = (state_r == BUSY) & ~bus.mem_ready;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
                .clk     (clk),
                .rst_n   (rst),
                .clr     (wd_clr_s),
                .en      (wd_en_s),
                .expired (expired_s)
            );
        end else begin : g_no_wdog
            assign expired_s = 1'b0;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.if_req || bus.d_req) state_s = BUSY;
                else                         state_s = IDLE;
            end
            BUSY: begin
                if (bus.mem_ready || expired_s) state_s = RESP;
                else                            state_s = BUSY;
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM event decode; mem_ready beats a same-cycle watchdog expiry
    always_comb begin
        start_s   = 1'b0;
        ready_s   = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.if_req || bus.d_req) start_s = 1'b1;
                else                         start_s = 1'b0;
            end
            BUSY: begin
                if (bus.mem_ready)  ready_s   = 1'b1;
                else if (expired_s) timeout_s = 1'b1;
                else                ready_s   = 1'b0;
            end
            RESP:    start_s = 1'b0;
            default: start_s = 1'b0;
        endcase
    end

    // Grant latches, read-data capture, done pulses and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r     <= OWN_IF;
            last_d_r    <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            if_done_r   <= 1'b0;
            d_done_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (start_s) begin
                owner_r     <= grant_d_s ? OWN_D : OWN_IF;
                mem_req_r   <= 1'b1;
                mem_we_r    <= grant_d_s & bus.d_we;
                mem_addr_r  <= grant_d_s ? bus.d_addr : bus.if_addr;
                mem_wdata_r <= grant_d_s ? bus.d_wdata : {DATA_W{1'b0}};
            end else if (finish_s) begin
                mem_req_r <= 1'b0;
                last_d_r  <= owner_r;
            end
            if (ready_s) begin
                if (owner_r == OWN_IF)  if_rdata_r <= bus.mem_rdata;
                else if (!mem_we_r)     d_rdata_r  <= bus.mem_rdata;
            end else if (timeout_s) begin
                if (owner_r == OWN_IF)  if_rdata_r <= FILL_WORD;
                else                    d_rdata_r  <= FILL_WORD;
                err_r <= 1'b1;
            end
            if_done_r <= finish_s & (owner_r == OWN_IF);
            d_done_r  <= finish_s & (owner_r == OWN_D);
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.if_done   = if_done_r;
    assign bus.d_done    = d_done_r;
    assign bus.err       = err_r;
    assign bus.stall_if  = bus.if_req & ~if_done_r;
    assign bus.stall_mem = bus.d_req & ~d_done_r;
endmodule
